// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-bank slave: FSM states, wait limit, lane helper.
package apb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_t;

  localparam int unsigned APB_MAX_WAIT = 15;

  // Number of byte lanes in a data word.
  function automatic int unsigned byte_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational base/range/alignment check turning a byte address into a register index.
module apb_addr_decode #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned IDX_W     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  index,
  output logic              err
);

  localparam int unsigned LANE_LG = $clog2(LANES);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word;

  assign offset = addr - BASE_ADDR;
  assign word   = offset >> LANE_LG;
  assign index  = word[IDX_W-1:0];

  // Below base wraps the offset, so the explicit base compare is needed alongside the range check.
  assign err = (addr < BASE_ADDR)
             | (word >= ADDR_W'(NUM_REGS))
             | ((offset & ADDR_W'(LANES - 1)) != '0);

endmodule

// File: rtl/apb_regbank_slave.sv
// APB slave exposing NUM_REGS word registers with wait states and PSLVERR on bad addresses.
// Byte-lane write strobes are enabled by defining APB_REGBANK_PSTRB_EN.
module apb_regbank_slave
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned NUM_REGS    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
`ifdef APB_REGBANK_PSTRB_EN
  input  logic [DATA_W/8-1:0]          pstrb,
`endif
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   reg_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int unsigned LANES = byte_lanes(DATA_W);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W = $clog2(APB_MAX_WAIT + 1);

  apb_state_t        state, next_state;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic              setup;
  logic [IDX_W-1:0]  index;
  logic              err;
  logic              wr_en;
  logic [LANES-1:0]  lane_en;
  logic [DATA_W-1:0] regs [NUM_REGS];

  assign setup = (state == ST_IDLE) & psel & ~penable;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (setup) begin
        addr_q  <= paddr;
        write_q <= pwrite;
      end
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    pready     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (setup) begin
          next_state = ST_ACCESS;
          cnt_next   = CNT_W'(WAIT_CYCLES);
        end
      end
      ST_ACCESS: begin
        pready = psel & penable & (cnt == '0);
        if (cnt != '0) cnt_next = cnt - CNT_W'(1);
        // Deselect mid-access is an abort; completion also ends the transfer.
        if (!psel || pready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  apb_addr_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_REGS  (NUM_REGS),
    .LANES     (LANES),
    .IDX_W     (IDX_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .addr  (addr_q),
    .index (index),
    .err   (err)
  );

  assign pslverr = pready & err;
  assign prdata  = (pready & ~write_q & ~err) ? regs[index] : '0;
  assign wr_en   = pready & write_q & ~err;

`ifdef APB_REGBANK_PSTRB_EN
  assign lane_en = pstrb;
`else
  assign lane_en = '1;
`endif

  // Register storage and the one-cycle write pulse, both updated on the commit edge.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (wr_en) begin
        wr_pulse_o[index] <= 1'b1;
        for (int b = 0; b < int'(LANES); b++) begin
          if (lane_en[b]) regs[index][b*8 +: 8] <= pwdata[b*8 +: 8];
        end
      end
    end
  end

  for (genvar gi = 0; gi < int'(NUM_REGS); gi++) begin : g_flat
    assign reg_o[gi*DATA_W +: DATA_W] = regs[gi];
  end

endmodule
